polybius_modified_encrypt: RTL and testbench

//  Modified Polybius-square encoder: maps one ASCII character per cycle to a

---
 rtl/polybius_modified_encrypt_pkg.sv | 31 +++
 rtl/polybius_modified_encrypt_lut.sv | 40 ++++
 rtl/polybius_modified_encrypt.sv | 55 +++++
 tb/tb_polybius_modified_encrypt.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/polybius_modified_encrypt_pkg.sv
// Shared constants and index-to-code helpers for the modified Polybius encoder.
// The 6x6 square holds A-Z (indices 0..25) followed by 0-9 (indices 26..35).
package polybius_modified_encrypt_pkg;

  localparam int          SQ_DIM               = 6;
  localparam logic [7:0]  ASCII_A              = 8'h41;
  localparam logic [7:0]  ASCII_a              = 8'h61;
  localparam logic [7:0]  ASCII_0              = 8'h30;
  localparam logic [7:0]  DEFAULT_INVALID_CODE = 8'd0;
  localparam logic [5:0]  DIGIT_BASE           = 6'd26;

  // Square row (1..6) of a linear index 0..35.
  function automatic logic [2:0] idx_to_row(input logic [5:0] n);
    return 3'(int'(n) / SQ_DIM + 1);
  endfunction

  // Square column (1..6) of a linear index 0..35.
  function automatic logic [2:0] idx_to_col(input logic [5:0] n);
    return 3'(int'(n) % SQ_DIM + 1);
  endfunction

  // Binary (not BCD) code 10*row + col, range 11..66.
  function automatic logic [7:0] idx_to_code(input logic [5:0] n);
    int r;
    int c;
    r = int'(n) / SQ_DIM + 1;
    c = int'(n) % SQ_DIM + 1;
    return 8'(10 * r + c);
  endfunction

endpackage

// File: rtl/polybius_modified_encrypt_lut.sv
// Combinational character-to-square lookup: ASCII in, row/col/code/invalid out.
module polybius_lut
  import polybius_modified_encrypt_pkg::*;
#(
  parameter logic [7:0] INVALID_CODE = DEFAULT_INVALID_CODE,
  parameter bit         CASE_FOLD    = 1'b1
) (
  input  logic [7:0] char_in,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic [7:0] code,
  output logic       invalid
);

  logic [5:0] idx;
  logic       hit;

  // Classify the byte and form its linear square index; the low six bits of
  // each ASCII range are enough because the range bases share their top bits.
  always_comb begin
    idx = '0;
    hit = 1'b0;
    if (char_in >= ASCII_A && char_in <= ASCII_A + 8'd25) begin
      idx = char_in[5:0] - ASCII_A[5:0];
      hit = 1'b1;
    end else if (CASE_FOLD && char_in >= ASCII_a && char_in <= ASCII_a + 8'd25) begin
      idx = char_in[5:0] - ASCII_a[5:0];
      hit = 1'b1;
    end else if (char_in >= ASCII_0 && char_in <= ASCII_0 + 8'd9) begin
      idx = DIGIT_BASE + (char_in[5:0] - ASCII_0[5:0]);
      hit = 1'b1;
    end
  end

  assign row     = hit ? idx_to_row(idx)  : 3'd0;
  assign col     = hit ? idx_to_col(idx)  : 3'd0;
  assign code    = hit ? idx_to_code(idx) : INVALID_CODE;
  assign invalid = ~hit;

endmodule

// File: rtl/polybius_modified_encrypt.sv
// Modified Polybius-square encoder: one ASCII character per cycle in,
// registered row/column code out one cycle later.
module polybius_modified_encrypt
  import polybius_modified_encrypt_pkg::*;
#(
  parameter logic [7:0] INVALID_CODE = DEFAULT_INVALID_CODE,
  parameter bit         CASE_FOLD    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] char_in,
  output logic       out_valid,
  output logic [7:0] encrypted,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       invalid
);

  logic [2:0] lut_row;
  logic [2:0] lut_col;
  logic [7:0] lut_code;
  logic       lut_invalid;

  polybius_lut #(
    .INVALID_CODE (INVALID_CODE),
    .CASE_FOLD    (CASE_FOLD)
  ) u_lut (
    .char_in (char_in),
    .row     (lut_row),
    .col     (lut_col),
    .code    (lut_code),
    .invalid (lut_invalid)
  );

  // Output registers: load on in_valid, otherwise hold data and drop out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      encrypted <= 8'd0;
      row       <= 3'd0;
      col       <= 3'd0;
      invalid   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        encrypted <= lut_code;
        row       <= lut_row;
        col       <= lut_col;
        invalid   <= lut_invalid;
      end
    end
  end

endmodule

// File: tb/tb_polybius_modified_encrypt.sv
// Self-checking bench for polybius_modified_encrypt: directed vector table,
// character sweep, random traffic against a string-search reference model,
// and hand-written reset / gap sequences. Two instances: CASE_FOLD=1 and 0.
module tb_polybius_modified_encrypt;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] char_in;

  logic       valid_f, valid_n;
  logic [7:0] enc_f,   enc_n;
  logic [2:0] row_f,   row_n;
  logic [2:0] col_f,   col_n;
  logic       inv_f,   inv_n;

  int checks   = 0;
  int failures = 0;

  // Expected register contents per instance: index 0 = fold, 1 = no fold.
  logic       m_valid;
  logic [7:0] m_code [2];
  logic [2:0] m_row  [2];
  logic [2:0] m_col  [2];
  logic       m_inv  [2];

  typedef struct {
    logic [7:0] ch;
    logic [7:0] code;
    logic [2:0] row;
    logic [2:0] col;
    logic       inv;
  } vec_t;

  vec_t vecs [15];

  polybius_modified_encrypt dut_fold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .char_in   (char_in),
    .out_valid (valid_f),
    .encrypted (enc_f),
    .row       (row_f),
    .col       (col_f),
    .invalid   (inv_f)
  );

  polybius_modified_encrypt #(.CASE_FOLD(1'b0)) dut_nofold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .char_in   (char_in),
    .out_valid (valid_n),
    .encrypted (enc_n),
    .row       (row_n),
    .col       (col_n),
    .invalid   (inv_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: locate the (optionally upper-cased) character in the square text.
  function automatic void ref_enc(input logic [7:0] c, input bit fold,
                                  output logic [7:0] code, output logic [2:0] r,
                                  output logic [2:0] cl, output logic inv);
    string      sq;
    logic [7:0] u;
    sq   = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
    u    = c;
    if (fold && c >= 8'h61 && c <= 8'h7A) u = c - 8'd32;
    code = 8'd0;
    r    = 3'd0;
    cl   = 3'd0;
    inv  = 1'b1;
    for (int p = 0; p < 36; p++) begin
      if (8'(sq[p]) == u) begin
        r    = 3'(p / 6 + 1);
        cl   = 3'(p % 6 + 1);
        code = 8'(10 * (p / 6 + 1) + (p % 6 + 1));
        inv  = 1'b0;
      end
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " fold out_valid"}, 32'(valid_f), 32'(m_valid));
    chk({tag, " fold encrypted"}, 32'(enc_f),   32'(m_code[0]));
    chk({tag, " fold row"},       32'(row_f),   32'(m_row[0]));
    chk({tag, " fold col"},       32'(col_f),   32'(m_col[0]));
    chk({tag, " fold invalid"},   32'(inv_f),   32'(m_inv[0]));
    chk({tag, " nofold out_valid"}, 32'(valid_n), 32'(m_valid));
    chk({tag, " nofold encrypted"}, 32'(enc_n),   32'(m_code[1]));
    chk({tag, " nofold row"},       32'(row_n),   32'(m_row[1]));
    chk({tag, " nofold col"},       32'(col_n),   32'(m_col[1]));
    chk({tag, " nofold invalid"},   32'(inv_n),   32'(m_inv[1]));
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_code[i] = 8'd0;
      m_row[i]  = 3'd0;
      m_col[i]  = 3'd0;
      m_inv[i]  = 1'b0;
    end
  endtask

  // Drive one input cycle (at negedge), then check both instances after the edge.
  task automatic step(input logic v, input logic [7:0] c, input string tag);
    @(negedge clk);
    in_valid = v;
    char_in  = c;
    @(posedge clk);
    #1;
    m_valid = v;
    if (v) begin
      ref_enc(c, 1'b1, m_code[0], m_row[0], m_col[0], m_inv[0]);
      ref_enc(c, 1'b0, m_code[1], m_row[1], m_col[1], m_inv[1]);
    end
    cmp_model(tag);
  endtask

  initial begin
    vecs[0]  = '{8'h41, 8'd11, 3'd1, 3'd1, 1'b0}; // A
    vecs[1]  = '{8'h46, 8'd16, 3'd1, 3'd6, 1'b0}; // F
    vecs[2]  = '{8'h47, 8'd21, 3'd2, 3'd1, 1'b0}; // G
    vecs[3]  = '{8'h58, 8'd46, 3'd4, 3'd6, 1'b0}; // X
    vecs[4]  = '{8'h5A, 8'd52, 3'd5, 3'd2, 1'b0}; // Z
    vecs[5]  = '{8'h30, 8'd53, 3'd5, 3'd3, 1'b0}; // 0
    vecs[6]  = '{8'h33, 8'd56, 3'd5, 3'd6, 1'b0}; // 3
    vecs[7]  = '{8'h34, 8'd61, 3'd6, 3'd1, 1'b0}; // 4
    vecs[8]  = '{8'h39, 8'd66, 3'd6, 3'd6, 1'b0}; // 9
    vecs[9]  = '{8'h61, 8'd11, 3'd1, 3'd1, 1'b0}; // a (folded)
    vecs[10] = '{8'h7A, 8'd52, 3'd5, 3'd2, 1'b0}; // z (folded)
    vecs[11] = '{8'h20, 8'd0,  3'd0, 3'd0, 1'b1}; // space
    vecs[12] = '{8'h3A, 8'd0,  3'd0, 3'd0, 1'b1}; // :
    vecs[13] = '{8'h80, 8'd0,  3'd0, 3'd0, 1'b1};
    vecs[14] = '{8'hFF, 8'd0,  3'd0, 3'd0, 1'b1};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    char_in  = 8'h00;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    cmp_model("reset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 8'h41, "idle after reset");

    // Directed table, back-to-back, checked against fixed expectations
    for (int i = 0; i < 15; i++) begin
      step(1'b1, vecs[i].ch, "table model");
      chk($sformatf("table[%0d] valid", i),   32'(valid_f), 32'd1);
      chk($sformatf("table[%0d] code", i),    32'(enc_f),   32'(vecs[i].code));
      chk($sformatf("table[%0d] row", i),     32'(row_f),   32'(vecs[i].row));
      chk($sformatf("table[%0d] col", i),     32'(col_f),   32'(vecs[i].col));
      chk($sformatf("table[%0d] invalid", i), 32'(inv_f),   32'(vecs[i].inv));
    end

    // Lowercase with folding disabled
    step(1'b1, 8'h61, "nofold a");
    chk("nofold a invalid", 32'(inv_n), 32'd1);
    chk("nofold a code",    32'(enc_n), 32'd0);
    step(1'b1, 8'h41, "nofold A");
    chk("nofold A code",    32'(enc_n), 32'd11);

    // Sweep '*'..'Z' back-to-back
    for (int c = 8'h2A; c <= 8'h5A; c++) step(1'b1, 8'(c), "sweep");

    // In-valid gap: data holds, out_valid drops
    step(1'b1, 8'h4B, "gap load K");
    chk("gap load K code", 32'(enc_f), 32'd25);
    step(1'b0, 8'h5A, "gap idle");
    chk("gap hold code",  32'(enc_f),   32'd25);
    chk("gap out_valid",  32'(valid_f), 32'd0);

    // Async reset mid-stream, between clock edges
    step(1'b1, 8'h51, "pre-reset Q");
    chk("pre-reset Q code", 32'(enc_f), 32'd35);
    @(negedge clk);
    in_valid = 1'b1;
    char_in  = 8'h52;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    cmp_model("async reset immediate");
    @(posedge clk);
    #1;
    cmp_model("reset held over edge");
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    cmp_model("pending char dropped");
    step(1'b1, 8'h52, "first after reset R");
    chk("first after reset R code", 32'(enc_f), 32'd36);

    // Random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      logic [7:0] c;
      c = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) c = 8'($urandom_range(8'h61, 8'h7A));
      step(1'($urandom_range(0, 3) != 0), c, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
